// File: rtl/arc4_pkg.sv
// arc4_pkg: shared FSM type, constants and helpers for the ARC4 datapath stages
package arc4_pkg;
    typedef enum logic [3:0] {
        IDLE, RD_LEN, WAIT_LEN, RD_SI, WAIT_SI, WAIT_SJ, WR_SJ, RD_PAD, WAIT_PAD
    } prga_state_t;
    localparam logic [7:0] LEN_OFFSET = 8'h00;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction
endpackage

// File: rtl/arc4_prga.sv
// arc4_prga: ARC4 keystream/decrypt stage, 6 cycles per byte; ARC4_PRGA_PRINTABLE_CHECK_EN adds pt_ok early abort
module arc4_prga
    import arc4_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [7:0]        s_addr,
    input  logic [7:0]        s_rddata,
    output logic [7:0]        s_wrdata,
    output logic              s_wren,
    output logic [ADDR_W-1:0] ct_addr,
    input  logic [7:0]        ct_rddata,
    output logic [ADDR_W-1:0] pt_addr,
    output logic [7:0]        pt_wrdata,
    output logic              pt_wren
`ifdef ARC4_PRGA_PRINTABLE_CHECK_EN
    ,
    output logic              pt_ok
`endif
);
    prga_state_t state, nxt;
    logic [7:0] i, j, k, len, si, sj, ctb, pad;
    logic stop;

    assign pad = s_rddata ^ ctb;
`ifdef ARC4_PRGA_PRINTABLE_CHECK_EN
    assign stop = !is_printable(pad);
`else
    assign stop = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    // next-state: one read/wait/swap/pad sequence per message byte
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:     nxt = en ? RD_LEN : IDLE;
            RD_LEN:   nxt = WAIT_LEN;
            WAIT_LEN: nxt = (ct_rddata == 8'd0) ? IDLE : RD_SI;
            RD_SI:    nxt = WAIT_SI;
            WAIT_SI:  nxt = WAIT_SJ;
            WAIT_SJ:  nxt = WR_SJ;
            WR_SJ:    nxt = RD_PAD;
            RD_PAD:   nxt = WAIT_PAD;
            WAIT_PAD: nxt = (k == len || stop) ? IDLE : RD_SI;
            default:  nxt = IDLE;
        endcase
    end

    // datapath registers: indices, length and the bytes captured from the memories
    always_ff @(posedge clk) begin
        if (rst) begin
            i <= 8'd0;
            j <= 8'd0;
            k <= 8'd0;
            len <= 8'd0;
            si <= 8'd0;
            sj <= 8'd0;
            ctb <= 8'd0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    i <= 8'd0;
                    j <= 8'd0;
                end
                WAIT_LEN: begin
                    len <= ct_rddata;
                    k <= 8'd1;
                    i <= 8'd1;
                end
                WAIT_SI: begin
                    si <= s_rddata;
                    ctb <= ct_rddata;
                    j <= j + s_rddata;
                end
                WAIT_SJ: sj <= s_rddata;
                WAIT_PAD: if (nxt == RD_SI) begin
                    k <= k + 8'd1;
                    i <= i + 8'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef ARC4_PRGA_PRINTABLE_CHECK_EN
    // pt_ok starts each message high and drops on the first non-printable plaintext byte
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && en)) pt_ok <= 1'b1;
        else if (state == WAIT_PAD && stop) pt_ok <= 1'b0;
    end
`endif

    // outputs: memory addresses, write data and enables decoded from the state
    always_comb begin
        rdy = state == IDLE;
        s_addr = (state == WAIT_SI) ? j + s_rddata :
                 (state == WR_SJ)   ? j :
                 (state == RD_PAD)  ? si + sj : i;
        s_wrdata = (state == WR_SJ) ? si : s_rddata;
        s_wren = state == WAIT_SJ || state == WR_SJ;
        ct_addr = (state == RD_LEN) ? ADDR_W'(LEN_OFFSET) : ADDR_W'(k);
        pt_addr = (state == WAIT_LEN) ? ADDR_W'(LEN_OFFSET) : ADDR_W'(k);
        pt_wrdata = (state == WAIT_LEN) ? ct_rddata : pad;
        pt_wren = state == WAIT_LEN || state == WAIT_PAD;
    end
endmodule
